// File: rtl/sampler_pipe.sv
// Pipelined weighted tree sampler: picks one topic index with probability proportional to its weight.
// Define SAMPLER_LFSR_EN to draw per-layer random fractions from internal LFSRs instead of i_random.
module sampler_pipe #(
    parameter int NUM_TOPICS     = 16,
    parameter int NUM_TOPICS_LOG = 4,
    parameter int PROB_W         = 32,
    parameter int TOPIC_W        = 32,
    parameter int RAND_W         = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_TOPICS_LOG:0]            i_ntopic,
    input  logic [NUM_TOPICS*PROB_W-1:0]       i_probs,
    input  logic [NUM_TOPICS*TOPIC_W-1:0]      i_topics,
    input  logic [NUM_TOPICS-1:0]              i_valid,
    input  logic [NUM_TOPICS_LOG*RAND_W-1:0]   i_random,
    input  logic                               i_in_valid,
    output logic                               o_in_ready,
    output logic                               o_out_valid,
    input  logic                               i_out_ready,
    output logic [TOPIC_W-1:0]                 o_new_topic,
    output logic [PROB_W+NUM_TOPICS_LOG-1:0]   o_prob_sum,
    output logic                               o_empty
);

    localparam int NODES  = 2 * NUM_TOPICS - 1;
    localparam int SUM_W  = PROB_W + NUM_TOPICS_LOG;
    localparam int PROD_W = SUM_W + RAND_W;
    localparam int RV_W   = NUM_TOPICS_LOG * RAND_W;
    localparam int NTW    = NUM_TOPICS_LOG + 1;

    // Nodes are stored level by level: leaves first, root last at NODES-1.
    function automatic int lvl_off(input int lvl);
        return 2 * NUM_TOPICS - 2 * (NUM_TOPICS >> lvl);
    endfunction

    logic [SUM_W-1:0]          p_reg   [NODES];
    logic [SUM_W-1:0]          p_next  [NODES];
    logic [TOPIC_W-1:0]        t_reg   [NODES];
    logic [TOPIC_W-1:0]        t_next  [NODES];
    logic                      v_reg   [NODES];
    logic                      v_next  [NODES];
    logic [RV_W-1:0]           rnd_reg [NUM_TOPICS_LOG];
    logic [RV_W-1:0]           rnd_in;
    logic [NUM_TOPICS_LOG:0]   vld_reg;
    logic [NUM_TOPICS_LOG:0]   vld_next;
    logic                      advance;
    logic                      accept;

    assign advance  = !vld_reg[NUM_TOPICS_LOG] || i_out_ready;
    assign accept   = i_in_valid && advance;
    assign vld_next = {vld_reg[NUM_TOPICS_LOG-1:0], i_in_valid};

    genvar gi, gk;

`ifdef SAMPLER_LFSR_EN
    for (gi = 0; gi < NUM_TOPICS_LOG; gi++) begin : g_lfsr
        logic [31:0] lfsr_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr_reg <= 32'hACE1 + 32'(gi);
            end else if (accept) begin
                lfsr_reg <= {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0);
            end
        end
        assign rnd_in[gi*RAND_W +: RAND_W] = lfsr_reg[31 -: RAND_W];
    end
    logic unused_random;
    assign unused_random = ^i_random;
`else
    assign rnd_in = i_random;
`endif

    // Leaf masking: invalid or out-of-range leaves carry zero weight and topic.
    for (gi = 0; gi < NUM_TOPICS; gi++) begin : g_leaf
        assign v_next[gi] = i_valid[gi] && (NTW'(gi) < i_ntopic);
        assign p_next[gi] = v_next[gi] ? SUM_W'(i_probs[gi*PROB_W +: PROB_W]) : '0;
        assign t_next[gi] = v_next[gi] ? i_topics[gi*TOPIC_W +: TOPIC_W] : '0;
    end

    // Stage gi reduces tree layer NUM_TOPICS_LOG-gi using the random slice carried by its request.
    for (gi = 1; gi <= NUM_TOPICS_LOG; gi++) begin : g_lvl
        for (gk = 0; gk < (NUM_TOPICS >> gi); gk++) begin : g_node
            localparam int LI    = lvl_off(gi - 1) + 2 * gk;
            localparam int NI    = lvl_off(gi) + gk;
            localparam int LAYER = NUM_TOPICS_LOG - gi;

            logic [SUM_W-1:0]  sum;
            logic [RAND_W-1:0] frac;
            logic [PROD_W-1:0] scaled;
            logic              vl;
            logic              vr;
            logic              pick_left;

            assign vl     = v_reg[LI];
            assign vr     = v_reg[LI+1];
            assign frac   = rnd_reg[gi-1][LAYER*RAND_W +: RAND_W];
            assign sum    = p_reg[LI] + p_reg[LI+1];
            assign scaled = (PROD_W'(sum) * PROD_W'(frac)) >> RAND_W;
            // A zero-sum pair with both children valid falls back to the left child.
            assign pick_left = vl && (!vr || (sum == '0) || (scaled < PROD_W'(p_reg[LI])));

            assign v_next[NI] = vl || vr;
            assign p_next[NI] = sum;
            assign t_next[NI] = pick_left ? t_reg[LI] : (vr ? t_reg[LI+1] : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
            for (int i = 0; i < NODES; i++) begin
                p_reg[i] <= '0;
                t_reg[i] <= '0;
                v_reg[i] <= 1'b0;
            end
            for (int j = 0; j < NUM_TOPICS_LOG; j++) begin
                rnd_reg[j] <= '0;
            end
        end else if (advance) begin
            vld_reg <= vld_next;
            for (int j = 0; j <= NUM_TOPICS_LOG; j++) begin
                if (vld_next[j]) begin
                    for (int i = lvl_off(j); i < lvl_off(j) + (NUM_TOPICS >> j); i++) begin
                        p_reg[i] <= p_next[i];
                        t_reg[i] <= t_next[i];
                        v_reg[i] <= v_next[i];
                    end
                end
            end
            if (accept) begin
                rnd_reg[0] <= rnd_in;
            end
            for (int j = 1; j < NUM_TOPICS_LOG; j++) begin
                if (vld_next[j]) begin
                    rnd_reg[j] <= rnd_reg[j-1];
                end
            end
        end
    end

    assign o_in_ready  = advance;
    assign o_out_valid = vld_reg[NUM_TOPICS_LOG];
    assign o_new_topic = t_reg[NODES-1];
    assign o_prob_sum  = p_reg[NODES-1];
    assign o_empty     = vld_reg[NUM_TOPICS_LOG] && !v_reg[NODES-1];

endmodule

// File: doc/sampler_pipe.md
Name: sampler_pipe

Overview:
- Parametrised, fully pipelined tree sampler for topic selection. Picks one topic index with probability proportional to its weight. Accepts one sample request per cycle.
- Successor to the combinational-tree sampler. Adds:
  - generic topic count and widths;
  - a valid/ready handshake with backpressure;
  - an explicit empty indication;
  - exact-width sum growth, so there is no overflow.
- Sits between the per-word probability computation and the topic-count update logic.

Parameters:
- NUM_TOPICS, 16, number of leaves; must be a power of two, at least 2.
- NUM_TOPICS_LOG, 4, log2(NUM_TOPICS).
- PROB_W, 32, width of each unsigned probability weight.
- TOPIC_W, 32, width of each topic id.
- RAND_W, 16, width of each per-layer random fraction.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_ntopic  in  NUM_TOPICS_LOG+1  number of active leaves; leaves with index >= i_ntopic are masked invalid
- i_probs  in  NUM_TOPICS*PROB_W  leaf weights; leaf k at bits [k*PROB_W +: PROB_W]
- i_topics  in  NUM_TOPICS*TOPIC_W  leaf topic ids; same packing as i_probs
- i_valid  in  NUM_TOPICS  per-leaf valid
- i_random  in  NUM_TOPICS_LOG*RAND_W  slice l is the uniform fraction used by tree layer l (layer 0 = root)
- i_in_valid  in  1  request valid
- o_in_ready  out  1  request accepted when i_in_valid & o_in_ready
- o_out_valid  out  1  result valid
- i_out_ready  in  1  result consumed when o_out_valid & i_out_ready
- o_new_topic  out  TOPIC_W  sampled topic id
- o_prob_sum  out  PROB_W+NUM_TOPICS_LOG  sum of all valid, unmasked weights
- o_empty  out  1  no valid leaf; o_new_topic = 0

Behaviour:
- Reset (async, rst=1): all pipeline valids clear. o_out_valid=0, o_new_topic=0, o_prob_sum=0, o_empty=0. o_in_ready=1 once rst is deasserted.
- Pipeline depth is NUM_TOPICS_LOG+1 stages:
  - Stage 0 registers the masked leaves, i_ntopic and the full i_random vector.
  - Stages 1..NUM_TOPICS_LOG each reduce one tree layer, leaf-parents first and root last.
  - Random slices travel with their request.
- Latency: accept in cycle N gives o_out_valid in cycle N+NUM_TOPICS_LOG+1 when there is no stall.
- Stall: advance = !o_out_valid | i_out_ready. o_in_ready = advance.
  - When advance=0, every stage holds. Outputs stay stable while o_out_valid=1 and i_out_ready=0.
  - Bubbles do not compress in this generation.
- Node rule, at layer l with children (pl, vl, tl) and (pr, vr, tr):
  - Masking: a leaf with v=0 is treated as p=0.
  - s = pl + pr, one bit wider than the child weight.
  - Output valid v = vl | vr.
  - Both children valid: t = (s * r_l) >> RAND_W. Pick left iff t < pl, else right.
  - Exactly one child valid: pick that child regardless of weight or random.
  - Neither child valid: v=0, topic=0, s=0.
  - s=0 with both children valid: pick left.
- Output fields:
  - o_empty = !(root v).
  - o_prob_sum = root s.
  - o_new_topic = root topic.
- Boundary cases:
  - i_ntopic=0: all leaves masked, so o_empty=1.
  - i_ntopic >= NUM_TOPICS: no masking.
  - r_l = all ones means t < s, so the right child is still reachable.
- Input change: input changes while o_in_ready=0 are ignored. Only handshaked requests enter the pipe.
- Reset mid-operation: all in-flight requests are discarded and no result is emitted.

Optional Feature:
- SAMPLER_LFSR_EN defined:
  - i_random is ignored.
  - NUM_TOPICS_LOG internal 32-bit Galois LFSRs (taps 32,22,2,1; distinct nonzero reset seeds 0xACE1+l) supply the top RAND_W bits per layer.
  - Each LFSR steps only on an accepted request.
- Not defined: random comes from i_random and no LFSR logic is built.

Test Plan:
- Single valid leaf: leaf 5 with p=100, topics[k]=100+k, i_ntopic=16, random arbitrary -> o_new_topic=105, o_prob_sum=100, o_empty=0, arriving 5 cycles after accept.
- Weighted pick, defaults: i_ntopic=2, p0=1, p1=3, both valid.
  - r3=0x0000 -> topic of leaf 0.
  - r3=0x8000 (t=2 >= 1) -> topic of leaf 1.
  - o_prob_sum=4 in both cases.
- Masking and empty: i_ntopic=4, only leaf 10 valid (p=7) -> o_empty=1, o_new_topic=0, o_prob_sum=0.
- Overflow: all 16 leaves valid, p=0xFFFFFFFF -> o_prob_sum=0xF_FFFFFFF0 (36 bits).
- Backpressure: 3 back-to-back requests with i_out_ready=0 -> first result holds stable and o_in_ready=0. Then raise i_out_ready -> results emerge in order, one per cycle.
- Reset mid-flight: assert rst for 1 cycle with 2 requests in the pipe -> o_out_valid=0 immediately, and no stale result appears afterwards.
